// File: rtl/maquina_lectura_if.sv
// rtl/maquina_lectura_if.sv - read-transaction handshake between the read sequencer and the bus-timing driver
interface maquina_lectura_if;
    logic       req;
    logic [7:0] addr_out;
    logic       dir_phase;
    logic       dat_valid;
    logic [7:0] data_in;
    logic       step_done;

    modport master (output req, addr_out, input dir_phase, dat_valid, data_in, step_done);
    modport slave  (input req, addr_out, output dir_phase, dat_valid, data_in, step_done);
endinterface

// File: rtl/maquina_lectura.sv
// rtl/maquina_lectura.sv - RTC read sequencer: walks clock (and optionally timer) registers, commits atomically
module maquina_lectura #(
    parameter bit         TIMER_EN = 1'b1,
    parameter logic [7:0] CLK_BASE = 8'h21,
    parameter logic [7:0] TMR_BASE = 8'h41
) (
    input  logic                  clk,
    input  logic                  reset,
    maquina_lectura_if.master     bus,
    input  logic                  leer,
    output logic [7:0]            Seg,
    output logic [7:0]            Min,
    output logic [7:0]            Hora,
    output logic [7:0]            Dia,
    output logic [7:0]            Mes,
    output logic [7:0]            Ano,
    output logic [7:0]            T_Seg,
    output logic [7:0]            T_Min,
    output logic [7:0]            T_Hora,
    output logic                  rd_done,
    output logic                  rd_err
);
    typedef enum logic [1:0] {IDLE, RD, GAP, DONE} state_t;

    localparam int         N    = TIMER_EN ? 9 : 6;
    localparam logic [3:0] LAST = TIMER_EN ? 4'd8 : 4'd5;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       err_q, err_d;
    logic [8:0] seen_q, seen_d;
    logic [7:0] shadow_q [0:8];
    logic [7:0] shadow_d [0:8];
    logic [7:0] vals_q [0:8];
    logic [7:0] vals_d [0:8];
    logic       req_q, req_d;
    logic [7:0] addr_q, addr_d;
    logic       rd_done_q, rd_done_d;
    logic       rd_err_q, rd_err_d;

    // The address phase indication is only informative for this sequencer.
    logic unused_dir_phase;
    assign unused_dir_phase = bus.dir_phase;

    function automatic logic [7:0] addr_of(logic [3:0] i);
        if (i < 4'd6) return CLK_BASE + {4'd0, i};
        else          return TMR_BASE + {4'd0, i} - 8'd6;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        seen_d    = seen_q;
        shadow_d  = shadow_q;
        vals_d    = vals_q;
        addr_d    = addr_q;
        rd_done_d = 1'b0;
        rd_err_d  = rd_err_q;
        case (state_q)
            IDLE: begin
                if (leer) begin
                    state_d = RD;
                    idx_d   = 4'd0;
                    err_d   = 1'b0;
                    seen_d  = '0;
                end
            end
            RD: begin
                if (bus.dat_valid) begin
                    shadow_d[idx_q] = bus.data_in;
                    seen_d[idx_q]   = 1'b1;
                end
                // seen_d already reflects a strobe coincident with step_done.
                if (bus.step_done) begin
                    if (!seen_d[idx_q]) err_d = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = GAP;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            GAP: state_d = RD;
            DONE: begin
                if (!err_q) begin
                    for (int i = 0; i < 9; i++) begin
                        if (i < N) vals_d[i] = shadow_q[i];
                    end
                end
                rd_done_d = 1'b1;
                rd_err_d  = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == RD);
        if (state_d == RD) addr_d = addr_of(idx_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            err_q     <= 1'b0;
            seen_q    <= '0;
            req_q     <= 1'b0;
            addr_q    <= 8'h00;
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= 8'h00;
                vals_q[i]   <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            rd_done_q <= rd_done_d;
            rd_err_q  <= rd_err_d;
            shadow_q  <= shadow_d;
            vals_q    <= vals_d;
        end
    end

    assign bus.req      = req_q;
    assign bus.addr_out = addr_q;
    assign Seg          = vals_q[0];
    assign Min          = vals_q[1];
    assign Hora         = vals_q[2];
    assign Dia          = vals_q[3];
    assign Mes          = vals_q[4];
    assign Ano          = vals_q[5];
    assign T_Seg        = vals_q[6];
    assign T_Min        = vals_q[7];
    assign T_Hora       = vals_q[8];
    assign rd_done      = rd_done_q;
    assign rd_err       = rd_err_q;
endmodule

// File: tb/tb_maquina_lectura.sv
// tb/tb_maquina_lectura.sv - self-checking bench for maquina_lectura with 9-read and 6-read instances
module tb_maquina_lectura;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       leer1 = 1'b0, leer0 = 1'b0;
    logic [7:0] v1 [9];
    logic [7:0] v0 [9];
    logic       done1, err1, done0, err0;

    maquina_lectura_if i1 ();
    maquina_lectura_if i0 ();

    maquina_lectura #(.TIMER_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(i1), .leer(leer1),
        .Seg(v1[0]), .Min(v1[1]), .Hora(v1[2]), .Dia(v1[3]), .Mes(v1[4]), .Ano(v1[5]),
        .T_Seg(v1[6]), .T_Min(v1[7]), .T_Hora(v1[8]), .rd_done(done1), .rd_err(err1)
    );
    maquina_lectura #(.TIMER_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(i0), .leer(leer0),
        .Seg(v0[0]), .Min(v0[1]), .Hora(v0[2]), .Dia(v0[3]), .Mes(v0[4]), .Ano(v0[5]),
        .T_Seg(v0[6]), .T_Min(v0[7]), .T_Hora(v0[8]), .rd_done(done0), .rd_err(err0)
    );

    int checks = 0;
    int errors = 0;
    // Reference model: committed values, bytes handed out this sequence, pending outcome.
    logic [7:0] exp_v  [2][9];
    logic [7:0] pend_v [2][9];
    logic       pend_valid [2];
    logic       pend_err [2];
    int         exp_pulses [2];
    int         seen_pulses [2];
    logic       leer_hold = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic logic get_req(int s);  return (s != 0) ? i1.req : i0.req; endfunction
    function automatic logic [7:0] get_addr(int s); return (s != 0) ? i1.addr_out : i0.addr_out; endfunction
    function automatic logic get_done(int s); return (s != 0) ? done1 : done0; endfunction
    function automatic logic get_err(int s);  return (s != 0) ? err1 : err0; endfunction
    function automatic logic [7:0] get_val(int s, int i); return (s != 0) ? v1[i] : v0[i]; endfunction

    function automatic logic [7:0] tbl(int i);
        logic [7:0] a;
        if (i < 6) a = 8'(8'h21 + i);
        else       a = 8'(8'h41 + i - 6);
        return a;
    endfunction

    task automatic set_drv(int s, logic dv, logic [7:0] d, logic sd);
        if (s != 0) begin i1.dat_valid = dv; i1.data_in = d; i1.step_done = sd; end
        else        begin i0.dat_valid = dv; i0.data_in = d; i0.step_done = sd; end
    endtask

    task automatic set_leer(int s, logic v);
        if (s != 0) leer1 = v; else leer0 = v;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            pend_valid[s] = 1'b0;
            pend_err[s]   = 1'b0;
            for (int i = 0; i < 9; i++) begin
                exp_v[s][i]  = 8'h00;
                pend_v[s][i] = 8'h00;
            end
        end
    endtask

    // Plays the driver for one whole read sequence on instance s.
    task automatic run_seq(int s, logic [7:0] base, int omit, bit coinc, bit toggle, bit chain, int abort_at);
        int   n;
        logic e;
        logic dv;
        n = (s != 0) ? 9 : 6;
        e = 1'b0;
        if (!chain) begin
            @(negedge clk);
            set_leer(s, 1'b1);
        end
        @(negedge clk);
        for (int idx = 0; idx < n; idx++) begin
            chk("req_high", get_req(s), 1);
            chk("addr", get_addr(s), tbl(idx));
            if (idx == 0) set_leer(s, leer_hold);
            if (idx == abort_at) begin
                #2 reset = 1'b1;
                clear_model();
                #1;
                chk("rst_req", get_req(s), 0);
                chk("rst_addr", get_addr(s), 0);
                chk("rst_done", get_done(s), 0);
                for (int i = 0; i < 9; i++) chk("rst_val", get_val(s, i), 0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            dv = (idx != omit);
            if (!dv) e = 1'b1;
            else     pend_v[s][idx] = 8'(base + idx);
            if (idx == n - 1) begin
                pend_err[s]   = e;
                pend_valid[s] = 1'b1;
                exp_pulses[s]++;
            end
            if (coinc) begin
                set_drv(s, dv, 8'(base + idx), 1'b1);
                @(negedge clk);
                set_drv(s, 1'b0, 8'h00, 1'b0);
            end else begin
                set_drv(s, dv, 8'(base + idx), 1'b0);
                @(negedge clk);
                set_drv(s, 1'b0, 8'h00, 1'b0);
                for (int k = 0; k < 3; k++) begin
                    if (toggle) set_leer(s, (k % 2) == 0);
                    @(negedge clk);
                end
                set_leer(s, leer_hold);
                set_drv(s, 1'b0, 8'h00, 1'b1);
                @(negedge clk);
                set_drv(s, 1'b0, 8'h00, 1'b0);
            end
            chk("gap_req_low", get_req(s), 0);
            if (idx < n - 1) begin
                @(negedge clk);
            end else begin
                chk("done_early", get_done(s), 0);
                @(negedge clk);
                chk("done_pulse", get_done(s), 1);
                if (!leer_hold) begin
                    @(negedge clk);
                    chk("done_clear", get_done(s), 0);
                    chk("idle_req", get_req(s), 0);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                if (get_done(s)) begin
                    chk("done_expected", pend_valid[s], 1);
                    if (pend_valid[s]) begin
                        chk("rd_err", get_err(s), pend_err[s]);
                        if (!pend_err[s]) begin
                            for (int i = 0; i < ((s != 0) ? 9 : 6); i++) exp_v[s][i] = pend_v[s][i];
                        end
                        pend_valid[s] = 1'b0;
                        seen_pulses[s]++;
                    end
                end
                for (int i = 0; i < 9; i++) chk("value", get_val(s, i), exp_v[s][i]);
            end
        end
    end

    initial begin
        exp_pulses[0] = 0; exp_pulses[1] = 0;
        seen_pulses[0] = 0; seen_pulses[1] = 0;
        clear_model();
        set_drv(0, 1'b0, 8'h00, 1'b0);
        set_drv(1, 1'b0, 8'h00, 1'b0);
        i1.dir_phase = 1'b0;
        i0.dir_phase = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("idle_req", get_req(s), 0);
            chk("idle_addr", get_addr(s), 0);
            chk("idle_done", get_done(s), 0);
        end

        run_seq(1, 8'h30, -1, 1'b0, 1'b0, 1'b0, -1);
        chk("lit_seg", v1[0], 8'h30);
        chk("lit_ano", v1[5], 8'h35);
        chk("lit_tseg", v1[6], 8'h36);
        chk("lit_thora", v1[8], 8'h38);

        run_seq(1, 8'h50, 4, 1'b0, 1'b0, 1'b0, -1);
        chk("lit_keep_mes", v1[4], 8'h34);
        chk("lit_keep_seg", v1[0], 8'h30);

        run_seq(0, 8'h60, -1, 1'b1, 1'b0, 1'b0, -1);
        chk("lit_t0_ano", v0[5], 8'h65);
        chk("lit_t0_seg", v0[0], 8'h60);
        chk("lit_t0_tseg", v0[6], 8'h00);

        run_seq(1, 8'h70, -1, 1'b0, 1'b0, 1'b0, 3);
        run_seq(1, 8'h70, -1, 1'b0, 1'b0, 1'b0, -1);
        chk("lit_after_abort", v1[8], 8'h78);

        leer_hold = 1'b1;
        run_seq(1, 8'h80, -1, 1'b0, 1'b0, 1'b0, -1);
        run_seq(1, 8'h90, -1, 1'b0, 1'b1, 1'b1, -1);
        leer_hold = 1'b0;
        run_seq(1, 8'hA0, -1, 1'b0, 1'b0, 1'b1, -1);
        chk("lit_b2b_hora", v1[2], 8'hA2);

        repeat (5) @(negedge clk);
        chk("pulses1", seen_pulses[1], exp_pulses[1]);
        chk("pulses0", seen_pulses[0], exp_pulses[0]);
        chk("pulses1_lit", exp_pulses[1], 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual %0t required finish", $time);
        $fatal(1);
    end
endmodule
